// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow out for a single bit position
  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B computed LSB first, one bit per clock,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_diff,
  output logic             m_borrow,
  output logic             m_overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic             cell_d;
  logic             cell_bo;

  full_subtractor u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Partial result only needs WIDTH-1 bits; the final bit joins it on the last cycle
  always_comb begin
    r_next = {cell_d, r_sr};
  end

  // Control FSM, operand/result shifting and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b1;
      m_valid    <= 1'b0;
      m_diff     <= '0;
      m_borrow   <= 1'b0;
      m_overflow <= 1'b0;
      cnt        <= '0;
      borrow     <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            a_sr    <= s_a;
            b_sr    <= s_b;
            a_msb   <= s_a[WIDTH-1];
            b_msb   <= s_b[WIDTH-1];
            borrow  <= 1'b0;
            cnt     <= '0;
            s_ready <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          r_sr   <= r_next[WIDTH-1:1];
          borrow <= cell_bo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            m_diff     <= r_next;
            m_borrow   <= cell_bo;
            m_overflow <= (a_msb != b_msb) && (cell_d != a_msb);
            m_valid    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor: computes A - B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Counterpart to the team's full adder: where the adder sums, this block subtracts, sequentially over WIDTH cycles.
- Valid/ready handshake on both sides; intended as a small-area arithmetic unit feeding the team's datapath and teaching examples.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- s_valid  input  1  operand pair valid
- s_ready  output  1  block can accept operands
- s_a  input  WIDTH  minuend
- s_b  input  WIDTH  subtrahend
- m_valid  output  1  result valid
- m_ready  input  1  downstream accepts result
- m_diff  output  WIDTH  A - B modulo 2^WIDTH
- m_borrow  output  1  final borrow out; 1 iff unsigned A < B
- m_overflow  output  1  signed overflow of A - B

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; s_ready=1, m_valid=0, m_diff=0, m_borrow=0, m_overflow=0; bit counter=0, borrow register=0. Reset takes priority over every other event, including mid-RUN and in DONE; any in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE: s_ready=1. On s_valid&&s_ready, latch s_a, s_b into shift registers, clear borrow and counter, go to RUN.
- RUN: s_ready=0, s_valid ignored.
  - Each cycle, the cell takes a=A[0], b=B[0], bi=borrow and produces d, bo.
  - d is shifted into the MSB of the result register; A and B shift right; borrow<=bo; counter++.
  - After the cycle processing bit WIDTH-1 (counter==WIDTH-1), go to DONE.
- DONE: m_valid=1. m_diff, m_borrow and m_overflow are stable and held until m_valid&&m_ready. On that handshake, go to IDLE.
  - s_ready rises in the following cycle; there is no same-cycle accept.
- Latency: handshake accepted at edge k; m_valid visible after edge k+WIDTH, i.e. exactly WIDTH cycles of RUN. Throughput is one operation per WIDTH+2 cycles minimum with m_ready tied high.
- Arithmetic:
  - Cell: d = a ^ b ^ bi; bo = (~a & b) | (~(a ^ b) & bi).
  - m_borrow = borrow after bit WIDTH-1.
  - m_overflow = (A[MSB] != B[MSB]) && (m_diff[MSB] != A[MSB]), using the latched A and B MSBs.
- Boundaries:
  - A == B gives diff 0, borrow 0, overflow 0.
  - 0 - 1 wraps to all-ones with borrow 1.
  - Operand changes on s_a/s_b after acceptance have no effect.
  - m_ready high outside DONE has no effect.
- m_diff/m_borrow/m_overflow retain their last values outside DONE; only m_valid qualifies them.

Decomposition:
- Package serial_sub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t
  - localparam DEFAULT_WIDTH = 8
- Sub-module full_subtractor: purely combinational, ports a, b, bi, d, bo; instantiated once in serial_subtractor.
- Counter width is $clog2(WIDTH).

Test Plan:
- Reset, then 0x05 - 0x03 with m_ready=1 -> m_diff=0x02, m_borrow=0, m_overflow=0; m_valid after exactly 8 RUN cycles, high for one cycle.
- 0x03 - 0x05 -> m_diff=0xFE, m_borrow=1, m_overflow=0. Then 0x00 - 0x01 -> 0xFF, borrow 1, overflow 0.
- 0x80 - 0x01 -> 0x7F, borrow 0, overflow 1. Then 0x7F - 0xFF -> 0x80, borrow 1, overflow 1.
- Backpressure: hold m_ready=0 for 5 cycles in DONE -> m_valid and outputs stable throughout. s_valid asserted meanwhile with new operands -> s_ready=0, operands not taken. Release -> IDLE, s_ready=1 next cycle.
- Reset mid-RUN at bit 3 of 0x55 - 0x22 -> next cycle IDLE, s_ready=1, m_valid=0, outputs zero. A subsequent 0x10 - 0x10 -> 0x00, borrow 0.
- Back-to-back with s_valid held high and m_ready=1: operations issued every WIDTH+2 cycles. Randomized 500-op run is checked against a reference model for diff, borrow and overflow.
